// File: rtl/teak_action_gmem_fill.sv
// Fetches addr/count/seed parameters on go, fills gmem with seed+i in 4 KB-safe INCR bursts.
// Latency: go -> first awvalid 9 cycles; one burst outstanding. Optional TEAK_FILL_ERR_ABORT_EN.
// Backpressure: all handshakes hold payload until accepted; done_0Stop holds the done token.
module teak_action_gmem_fill #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int ID_WIDTH      = 1,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go_0Ready,
  output logic                    go_0Stop,
  output logic                    done_0Ready,
  input  logic                    done_0Stop,
  output logic                    paramaddr_0Ready,
  output logic [31:0]             paramaddr_0Data,
  input  logic                    paramaddr_0Stop,
  input  logic                    paramdata_0Ready,
  input  logic [31:0]             paramdata_0Data,
  output logic                    paramdata_0Stop,
  output logic [ADDR_WIDTH-1:0]   m_axi_gmem_awaddr,
  output logic [7:0]              m_axi_gmem_awlen,
  output logic [2:0]              m_axi_gmem_awsize,
  output logic [1:0]              m_axi_gmem_awburst,
  output logic [ID_WIDTH-1:0]     m_axi_gmem_awid,
  output logic                    m_axi_gmem_awvalid,
  input  logic                    m_axi_gmem_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_gmem_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_gmem_wstrb,
  output logic                    m_axi_gmem_wlast,
  output logic                    m_axi_gmem_wvalid,
  input  logic                    m_axi_gmem_wready,
  input  logic [1:0]              m_axi_gmem_bresp,
  input  logic                    m_axi_gmem_bvalid,
  output logic                    m_axi_gmem_bready
);

  localparam int BPB  = DATA_WIDTH / 8;
  localparam int SIZE = $clog2(BPB);

  typedef enum logic [2:0] {S_IDLE, S_PREQ, S_PWAIT, S_AW, S_W, S_B, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [1:0]            k;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           remaining;
  logic [DATA_WIDTH-1:0] fill_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_q;

  logic [12:0]           to_bound;
  logic [12:0]           bound_beats;
  logic [31:0]           beats_c;
  logic [7:0]            awlen_c;
  logic [8:0]            len_plus1;
  logic [31:0]           rem_after;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic                  err_abort;

`ifdef TEAK_FILL_ERR_ABORT_EN
  assign err_abort = m_axi_gmem_bresp[1];
`else
  logic bresp_unused;
  assign bresp_unused = ^m_axi_gmem_bresp;
  assign err_abort    = 1'b0;
`endif

  // Burst length is the smallest of what is left, the burst cap and the room to the 4 KB page end.
  assign to_bound    = 13'd4096 - {1'b0, addr_q[11:0]};
  assign bound_beats = to_bound >> SIZE;

  always_comb begin
    beats_c = remaining;
    if (beats_c > 32'(MAX_BURST_LEN)) beats_c = 32'(MAX_BURST_LEN);
    if (beats_c > {19'd0, bound_beats}) beats_c = {19'd0, bound_beats};
  end

  assign awlen_c     = 8'(beats_c - 32'd1);
  assign len_plus1   = {1'b0, len_q} + 9'd1;
  assign rem_after   = remaining - {23'd0, len_plus1};
  assign burst_bytes = ADDR_WIDTH'(len_plus1) << SIZE;

  assign paramaddr_0Data    = {28'd0, k, 2'b00};
  assign paramdata_0Stop    = 1'b0;
  assign m_axi_gmem_awaddr  = addr_q;
  assign m_axi_gmem_awlen   = awlen_c;
  assign m_axi_gmem_awsize  = 3'(SIZE);
  assign m_axi_gmem_awburst = 2'b01;
  assign m_axi_gmem_awid    = '0;
  assign m_axi_gmem_wdata   = fill_q;
  assign m_axi_gmem_wstrb   = '1;
  assign m_axi_gmem_wlast   = (state == S_W) && (beat_q == len_q);

  always_comb begin
    state_nxt          = state;
    go_0Stop           = 1'b1;
    done_0Ready        = 1'b0;
    paramaddr_0Ready   = 1'b0;
    m_axi_gmem_awvalid = 1'b0;
    m_axi_gmem_wvalid  = 1'b0;
    m_axi_gmem_bready  = 1'b0;
    case (state)
      S_IDLE: begin
        go_0Stop = ~reset;
        if (go_0Ready && reset) state_nxt = S_PREQ;
      end
      S_PREQ: begin
        paramaddr_0Ready = 1'b1;
        if (!paramaddr_0Stop) state_nxt = S_PWAIT;
      end
      S_PWAIT: begin
        if (paramdata_0Ready) state_nxt = (k == 2'd3) ? S_AW : S_PREQ;
      end
      S_AW: begin
        // A zero beat count falls straight through to DONE without touching the bus.
        if (remaining == 32'd0) begin
          state_nxt = S_DONE;
        end else begin
          m_axi_gmem_awvalid = 1'b1;
          if (m_axi_gmem_awready) state_nxt = S_W;
        end
      end
      S_W: begin
        m_axi_gmem_wvalid = 1'b1;
        if (m_axi_gmem_wready && m_axi_gmem_wlast) state_nxt = S_B;
      end
      S_B: begin
        m_axi_gmem_bready = 1'b1;
        if (m_axi_gmem_bvalid) state_nxt = (rem_after == 32'd0 || err_abort) ? S_DONE : S_AW;
      end
      S_DONE: begin
        done_0Ready = 1'b1;
        if (!done_0Stop) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      k         <= 2'd0;
      addr_q    <= '0;
      remaining <= 32'd0;
      fill_q    <= '0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: k <= 2'd0;
        S_PWAIT: begin
          if (paramdata_0Ready) begin
            k <= k + 2'd1;
            case (k)
              2'd0:    addr_q[31:0]            <= paramdata_0Data;
              2'd1:    addr_q[ADDR_WIDTH-1:32] <= paramdata_0Data[ADDR_WIDTH-33:0];
              2'd2:    remaining               <= paramdata_0Data;
              default: fill_q                  <= DATA_WIDTH'(paramdata_0Data);
            endcase
          end
        end
        S_AW: begin
          if (m_axi_gmem_awvalid && m_axi_gmem_awready) begin
            len_q  <= awlen_c;
            beat_q <= 8'd0;
          end
        end
        S_W: begin
          if (m_axi_gmem_wready) begin
            fill_q <= fill_q + DATA_WIDTH'(1);
            beat_q <= beat_q + 8'd1;
          end
        end
        S_B: begin
          if (m_axi_gmem_bvalid) begin
            addr_q    <= addr_q + burst_bytes;
            remaining <= rem_after;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_teak_action_gmem_fill.sv
// Directed bench for teak_action_gmem_fill: vector table of fill operations plus reset and done-hold sequences.
module tb_teak_action_gmem_fill;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go_0Ready = 1'b0, go_0Stop;
  logic        done_0Ready, done_0Stop = 1'b0;
  logic        paramaddr_0Ready, paramaddr_0Stop = 1'b0;
  logic [31:0] paramaddr_0Data;
  logic        paramdata_0Ready = 1'b0, paramdata_0Stop;
  logic [31:0] paramdata_0Data = 32'd0;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [0:0]  awid;
  logic        awvalid, awready = 1'b0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  teak_action_gmem_fill dut (
    .clk(clk), .reset(reset),
    .go_0Ready(go_0Ready), .go_0Stop(go_0Stop),
    .done_0Ready(done_0Ready), .done_0Stop(done_0Stop),
    .paramaddr_0Ready(paramaddr_0Ready), .paramaddr_0Data(paramaddr_0Data), .paramaddr_0Stop(paramaddr_0Stop),
    .paramdata_0Ready(paramdata_0Ready), .paramdata_0Data(paramdata_0Data), .paramdata_0Stop(paramdata_0Stop),
    .m_axi_gmem_awaddr(awaddr), .m_axi_gmem_awlen(awlen), .m_axi_gmem_awsize(awsize),
    .m_axi_gmem_awburst(awburst), .m_axi_gmem_awid(awid), .m_axi_gmem_awvalid(awvalid),
    .m_axi_gmem_awready(awready), .m_axi_gmem_wdata(wdata), .m_axi_gmem_wstrb(wstrb),
    .m_axi_gmem_wlast(wlast), .m_axi_gmem_wvalid(wvalid), .m_axi_gmem_wready(wready),
    .m_axi_gmem_bresp(bresp), .m_axi_gmem_bvalid(bvalid), .m_axi_gmem_bready(bready)
  );

  typedef struct {
    logic [31:0] lo, hi, n, seed;
    int          nb;
    logic [63:0] a[3];
    logic [7:0]  l[3];
    bit          stall;
    int          err_burst;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [31:0] lo, hi, n, seed, input int nb,
                         input logic [63:0] a0, input logic [7:0] l0,
                         input logic [63:0] a1, input logic [7:0] l1,
                         input logic [63:0] a2, input logic [7:0] l2,
                         input bit stall, input int err_burst);
    vt[i].lo = lo; vt[i].hi = hi; vt[i].n = n; vt[i].seed = seed; vt[i].nb = nb;
    vt[i].a[0] = a0; vt[i].a[1] = a1; vt[i].a[2] = a2;
    vt[i].l[0] = l0; vt[i].l[1] = l1; vt[i].l[2] = l2;
    vt[i].stall = stall; vt[i].err_burst = err_burst;
  endtask

  // Issues go; returns the sample cycle in which the go transfer was presented.
  task automatic do_go(output int go_cyc);
    int guard = 0;
    go_0Ready = 1'b1;
    while (go_0Stop && guard < 20) begin tick(); guard++; end
    if (guard >= 20) check("go_timeout", 0, 1);
    go_cyc = cyc;
    tick();
    go_0Ready = 1'b0;
  endtask

  task automatic do_params(input logic [31:0] lo, hi, n, seed, input bit stall);
    logic [31:0] pv[4];
    pv[0] = lo; pv[1] = hi; pv[2] = n; pv[3] = seed;
    for (int k = 0; k < 4; k++) begin
      int          guard = 0;
      bit          seen  = 1'b0;
      logic [31:0] held  = 32'd0;
      forever begin
        if (paramaddr_0Ready) begin
          if (!seen) begin
            held = paramaddr_0Data;
            seen = 1'b1;
            check("paramaddr", {32'd0, paramaddr_0Data}, 64'(4 * k));
          end else begin
            check("paramaddr_hold", {32'd0, paramaddr_0Data}, {32'd0, held});
          end
          paramaddr_0Stop = stall ? ($urandom_range(0, 2) == 0) : 1'b0;
          if (!paramaddr_0Stop) begin tick(); break; end
        end
        tick();
        guard++;
        if (guard > 50) begin check("paramaddr_timeout", 0, 1); paramaddr_0Stop = 1'b0; return; end
      end
      paramaddr_0Stop = 1'b0;
      if (stall) repeat ($urandom_range(0, 2)) tick();
      paramdata_0Ready = 1'b1;
      paramdata_0Data  = pv[k];
      tick();
      paramdata_0Ready = 1'b0;
    end
  endtask

  task automatic run_op(input int vi);
    vec_t        v;
    int          go_cyc, nb_seen, exp_nb, guard;
    logic [63:0] beat, held_addr;
    logic [7:0]  len;
    bit          aborted;
    v       = vt[vi];
    nb_seen = 0;
    beat    = 64'd0;
    aborted = 1'b0;
    do_go(go_cyc);
    do_params(v.lo, v.hi, v.n, v.seed, v.stall);
    forever begin
      guard = 0;
      while (!awvalid && !done_0Ready && guard < 200) begin tick(); guard++; end
      if (guard >= 200) begin check("aw_or_done_timeout", 0, 1); return; end
      if (done_0Ready) break;
      if (!v.stall && nb_seen == 0) check("aw_latency", 64'(cyc - go_cyc), 64'd9);
      if (nb_seen < 3) begin
        check("awaddr", awaddr, v.a[nb_seen]);
        check("awlen", {56'd0, awlen}, {56'd0, v.l[nb_seen]});
      end
      check("awsize_burst_strb", {awsize, awburst, awid, wstrb}, {3'd3, 2'b01, 1'b0, 8'hFF});
      held_addr = awaddr;
      len       = awlen;
      guard     = 0;
      forever begin
        check("w_before_aw", {63'd0, wvalid}, 64'd0);
        awready = v.stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (awready) begin tick(); break; end
        tick();
        check("aw_hold", {awaddr[55:0], awlen}, {held_addr[55:0], len});
        guard++;
        if (guard > 50) begin check("aw_timeout", 0, 1); awready = 1'b0; return; end
      end
      awready = 1'b0;
      for (int j = 0; j <= int'(len); j++) begin
        guard = 0;
        forever begin
          wready = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (wvalid && wready) begin
            check("wdata", wdata, {32'd0, v.seed} + beat);
            check("wlast", {63'd0, wlast}, {63'd0, j == int'(len)});
            tick();
            break;
          end
          tick();
          guard++;
          if (guard > 50) begin check("w_timeout", 0, 1); wready = 1'b0; return; end
        end
        beat++;
      end
      wready = 1'b0;
      bvalid = 1'b1;
      bresp  = (nb_seen == v.err_burst) ? 2'b10 : 2'b00;
      if (nb_seen == v.err_burst) aborted = 1'b1;
      guard  = 0;
      while (!bready && guard < 20) begin tick(); guard++; end
      if (guard >= 20) check("b_timeout", 0, 1);
      tick();
      bvalid = 1'b0;
      bresp  = 2'b00;
      nb_seen++;
      if (nb_seen > 5) break;
    end
    exp_nb = v.nb;
`ifdef TEAK_FILL_ERR_ABORT_EN
    if (v.err_burst >= 0) exp_nb = v.err_burst + 1;
    if (!aborted) check("beats", beat, {32'd0, v.n});
`else
    check("beats", beat, {32'd0, v.n});
`endif
    check("bursts", 64'(nb_seen), 64'(exp_nb));
    if (v.n == 32'd0 && !v.stall) check("done_latency", 64'(cyc - go_cyc), 64'd10);
    done_0Stop = 1'b1;
    repeat (3) begin
      tick();
      check("done_hold", {63'd0, done_0Ready}, 64'd1);
    end
    done_0Stop = 1'b0;
    tick();
    check("done_drop", {63'd0, done_0Ready}, 64'd0);
    check("idle_go_stop", {63'd0, go_0Stop}, 64'd0);
  endtask

  initial begin
    int go_cyc, guard;
    set_vec(0, 32'h1000, 32'h0, 32'd4, 32'h10, 1, 64'h1000, 8'd3, 64'h0, 8'd0, 64'h0, 8'd0, 1'b0, -1);
    set_vec(1, 32'h0, 32'h0, 32'd40, 32'h100, 3, 64'h0, 8'd15, 64'h80, 8'd15, 64'h100, 8'd7, 1'b0, -1);
    set_vec(2, 32'hFF0, 32'h0, 32'd8, 32'hABCD, 2, 64'hFF0, 8'd1, 64'h1000, 8'd5, 64'h0, 8'd0, 1'b0, -1);
    set_vec(3, 32'h4000, 32'h0, 32'd0, 32'h55, 0, 64'h0, 8'd0, 64'h0, 8'd0, 64'h0, 8'd0, 1'b0, -1);
    set_vec(4, 32'hFFFF_FF80, 32'h1, 32'd40, 32'hFFFF_FFF0, 3,
            64'h1_FFFF_FF80, 8'd15, 64'h2_0000_0000, 8'd15, 64'h2_0000_0080, 8'd7, 1'b1, -1);
    set_vec(5, 32'h2000, 32'h0, 32'd40, 32'h0, 3, 64'h2000, 8'd15, 64'h2080, 8'd15, 64'h2100, 8'd7, 1'b0, 0);
    set_vec(6, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd4, 32'h7, 2,
            64'hFFFF_FFFF_FFFF_FFF0, 8'd1, 64'h0, 8'd1, 64'h0, 8'd0, 1'b0, -1);

    repeat (3) tick();
    check("rst_go_stop", {63'd0, go_0Stop}, 64'd1);
    check("rst_valids", {59'd0, awvalid, wvalid, bready, done_0Ready, paramaddr_0Ready}, 64'd0);
    check("rst_pdata_stop", {63'd0, paramdata_0Stop}, 64'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_op(i);

    // Reset in the middle of a write burst, then a clean restart.
    do_go(go_cyc);
    do_params(32'h0, 32'h0, 32'd40, 32'h5, 1'b0);
    guard = 0;
    while (!awvalid && guard < 50) begin tick(); guard++; end
    check("mid_aw_seen", {63'd0, awvalid}, 64'd1);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b1;
    tick();
    tick();
    check("mid_w_active", {63'd0, wvalid}, 64'd1);
    check("mid_wdata", wdata, 64'h7);
    reset = 1'b0;
    tick();
    wready = 1'b0;
    check("rstw_valids", {61'd0, wvalid, awvalid, bready}, 64'd0);
    check("rstw_go_stop", {63'd0, go_0Stop}, 64'd1);
    reset = 1'b1;
    tick();
    check("rstw_idle", {63'd0, go_0Stop}, 64'd0);
    run_op(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
